// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU: widths, address/instruction types and
// the fetch-stage state encoding used by fetch, ROM and decode.
package cpu_pkg;

  localparam int ADDR_W  = 4;
  localparam int INSTR_W = 8;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  typedef enum logic [1:0] {
    FS_RUN    = 2'd0,
    FS_END    = 2'd1,
    FS_HALTED = 2'd2
  } fetch_state_e;

  // Even parity over an instruction word, for decode-side integrity checks.
  function automatic logic instr_parity(input instr_t word);
    return ^word;
  endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter register: hold, jump load or increment, with a flag raised
// when the counter sits at its maximum value.
module program_counter
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              inc_en,
  output logic [ADDR_W-1:0] pc,
  output logic              at_max
);

  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] ONE        = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_q;

  // Next PC: hold wins, then jump target, then modular increment.
  always_comb begin
    pc_d = pc_q;
    if (hold) begin
      pc_d = pc_q;
    end else if (jump_en) begin
      pc_d = jump_addr;
    end else if (inc_en) begin
      pc_d = pc_q + ONE;
    end else begin
      pc_d = pc_q;
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_ADDR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc     = pc_q;
  assign at_max = &pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, latches ROM words into ir and hands them to decode
// over valid/ready. With IFETCH_WRAP_HALT_EN defined, fetching stops at the
// top of the ROM instead of wrapping to address 0.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int INSTR_W  = cpu_pkg::INSTR_W,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  addr,
  input  logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  input  logic               halt,
  output logic               halted
);

  fetch_state_e       state_d, state_q;
  logic [INSTR_W-1:0] ir_d, ir_q;
  logic [ADDR_W-1:0]  ir_pc_d, ir_pc_q;
  logic               ir_valid_d, ir_valid_q;
  logic               halted_d, halted_q;

  logic [ADDR_W-1:0]  pc_s;
  logic               pc_at_max_s;
  logic               pc_jump_s;
  logic               pc_inc_s;
  logic               pc_hold_s;
  logic               load_s;

  program_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .hold      (pc_hold_s),
    .jump_en   (pc_jump_s),
    .jump_addr (jump_addr),
    .inc_en    (pc_inc_s),
    .pc        (pc_s),
    .at_max    (pc_at_max_s)
  );

  assign load_s    = (state_q == FS_RUN) && (!ir_valid_q || ir_ready);
  assign pc_hold_s = !(pc_jump_s || pc_inc_s);

  // Next-state and datapath control; priority is halt > jump > load > hold.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    pc_jump_s  = 1'b0;
    pc_inc_s   = 1'b0;
    case (state_q)
      FS_RUN: begin
        if (halt) begin
          state_d    = FS_HALTED;
          ir_valid_d = 1'b0;
        end else if (jump_en) begin
          pc_jump_s  = 1'b1;
          ir_valid_d = 1'b0;
        end else if (load_s) begin
          ir_d       = instr;
          ir_pc_d    = pc_s;
          ir_valid_d = 1'b1;
`ifdef IFETCH_WRAP_HALT_EN
          // Last ROM word: park the PC rather than wrapping into address 0.
          if (pc_at_max_s) begin
            state_d = FS_END;
          end else begin
            pc_inc_s = 1'b1;
          end
`else
          pc_inc_s = 1'b1;
`endif
        end else begin
          ir_valid_d = ir_valid_q;
        end
      end
`ifdef IFETCH_WRAP_HALT_EN
      FS_END: begin
        if (halt) begin
          state_d    = FS_HALTED;
          ir_valid_d = 1'b0;
        end else if (jump_en) begin
          pc_jump_s  = 1'b1;
          ir_valid_d = 1'b0;
          state_d    = FS_RUN;
        end else if (ir_valid_q && ir_ready) begin
          ir_valid_d = 1'b0;
          state_d    = FS_HALTED;
        end else begin
          ir_valid_d = ir_valid_q;
        end
      end
`endif
      FS_HALTED: begin
        state_d    = FS_HALTED;
        ir_valid_d = 1'b0;
      end
      default: begin
        state_d    = FS_HALTED;
        ir_valid_d = 1'b0;
      end
    endcase
    halted_d = (state_d == FS_HALTED);
  end

  // State, instruction register and handshake flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FS_RUN;
      ir_q       <= {INSTR_W{1'b0}};
      ir_pc_q    <= {ADDR_W{1'b0}};
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
    end
  end

  assign addr     = pc_s;
  assign ir       = ir_q;
  assign ir_pc    = ir_pc_q;
  assign ir_valid = ir_valid_q;
  assign halted   = halted_q;

endmodule
